uart_pkt_ctrl: RTL and testbench

Frame controller behind the UART receiver in the flash-update path. It consumes the receiver's single-cycle byte strobes and sequences them through a fixed frame format: header A5 5A, CMD, LEN, LEN payload bytes, then CHK. Payload bytes are forwarded as a stream to the flash-write buffer. Each frame ends with a done or error pulse, and the block recovers from line noise, bad checksums, bad lengths and stalled senders.

---
 rtl/uart_pkt_pkg.sv | 28 ++
 rtl/uart_gap_timer.sv | 27 ++
 rtl/uart_pkt_ctrl.sv | 151 +++++++++++++++
 tb/tb_uart_pkt_ctrl.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkt_pkg.sv
// Shared definitions for the UART frame controller: state encoding, header bytes, error codes.
package uart_pkt_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEAD1,
        ST_CMD,
        ST_LEN,
        ST_DATA,
        ST_CHK
    } state_t;

    localparam logic [7:0] HEAD0 = 8'hA5;
    localparam logic [7:0] HEAD1 = 8'h5A;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_CHK     = 2'd1,
        ERR_TIMEOUT = 2'd2,
        ERR_LEN     = 2'd3
    } err_code_t;

    function automatic logic [31:0] timeout_cycles(input int unsigned clk_freq,
                                                   input int unsigned timeout_us);
        return 32'((clk_freq / 1_000_000) * timeout_us);
    endfunction

endpackage

// File: rtl/uart_gap_timer.sv
// Inter-byte gap counter: counts while enabled, pulses expire for one cycle at TIMEOUT_CNT.
module uart_gap_timer #(
    parameter logic [31:0] TIMEOUT_CNT = 32'd50_000
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    logic [31:0] cnt;

    // Saturating so a lingering enable cannot wrap into a second expiry
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != TIMEOUT_CNT)) begin
            cnt <= cnt + 32'd1;
        end
    end

    assign expire = en && (cnt == TIMEOUT_CNT);

endmodule

// File: rtl/uart_pkt_ctrl.sv
// Frame controller: A5 5A CMD LEN payload CHK, with checksum, length and gap-timeout recovery.
module uart_pkt_ctrl
    import uart_pkt_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned TIMEOUT_US = 1000,
    parameter int unsigned MAX_LEN    = 255
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       rx_valid_i,
    input  logic [7:0] rx_data_i,
    output logic       pkt_start_o,
    output logic [7:0] pkt_cmd_o,
    output logic [7:0] pkt_len_o,
    output logic       pkt_data_valid_o,
    output logic [7:0] pkt_data_o,
    output logic       pkt_done_o,
    output logic       pkt_err_o,
    output logic [1:0] err_code_o,
    output logic       busy_o
);

    localparam logic [31:0] TIMEOUT_CNT = timeout_cycles(CLK_FREQ, TIMEOUT_US);
    localparam logic [8:0]  MAX_LEN_W   = 9'(MAX_LEN);

    state_t    state, state_n;
    err_code_t err_q, err_n;
    logic [7:0] cmd_q, cmd_n;
    logic [7:0] sum_q, sum_n;
    logic [7:0] rem_q, rem_n;
    logic [7:0] pkt_cmd_n, pkt_len_n, pkt_data_n;
    logic       start_n, dv_n, done_n, perr_n;
    logic       expire;

    uart_gap_timer #(
        .TIMEOUT_CNT (TIMEOUT_CNT)
    ) u_gap_timer (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .clr       (rx_valid_i || (state == ST_IDLE)),
        .en        (state != ST_IDLE),
        .expire    (expire)
    );

    always_comb begin
        state_n    = state;
        err_n      = err_q;
        cmd_n      = cmd_q;
        sum_n      = sum_q;
        rem_n      = rem_q;
        pkt_cmd_n  = pkt_cmd_o;
        pkt_len_n  = pkt_len_o;
        pkt_data_n = pkt_data_o;
        start_n    = 1'b0;
        dv_n       = 1'b0;
        done_n     = 1'b0;
        perr_n     = 1'b0;

        // A byte arriving on the expiry cycle takes priority over the timeout
        if (rx_valid_i) begin
            unique case (state)
                ST_IDLE: begin
                    if (rx_data_i == HEAD0) state_n = ST_HEAD1;
                end
                ST_HEAD1: begin
                    if (rx_data_i == HEAD1)      state_n = ST_CMD;
                    else if (rx_data_i != HEAD0) state_n = ST_IDLE;
                end
                ST_CMD: begin
                    cmd_n   = rx_data_i;
                    sum_n   = rx_data_i;
                    state_n = ST_LEN;
                end
                ST_LEN: begin
                    if ({1'b0, rx_data_i} > MAX_LEN_W) begin
                        perr_n  = 1'b1;
                        err_n   = ERR_LEN;
                        state_n = ST_IDLE;
                    end else begin
                        pkt_cmd_n = cmd_q;
                        pkt_len_n = rx_data_i;
                        start_n   = 1'b1;
                        err_n     = ERR_NONE;
                        sum_n     = sum_q + rx_data_i;
                        rem_n     = rx_data_i;
                        state_n   = (rx_data_i == 8'd0) ? ST_CHK : ST_DATA;
                    end
                end
                ST_DATA: begin
                    dv_n       = 1'b1;
                    pkt_data_n = rx_data_i;
                    sum_n      = sum_q + rx_data_i;
                    rem_n      = rem_q - 8'd1;
                    if (rem_q == 8'd1) state_n = ST_CHK;
                end
                ST_CHK: begin
                    if (rx_data_i == sum_q) begin
                        done_n = 1'b1;
                    end else begin
                        perr_n = 1'b1;
                        err_n  = ERR_CHK;
                    end
                    state_n = ST_IDLE;
                end
                default: state_n = ST_IDLE;
            endcase
        end else if (expire) begin
            state_n = ST_IDLE;
            if (state != ST_HEAD1) begin
                perr_n = 1'b1;
                err_n  = ERR_TIMEOUT;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state            <= ST_IDLE;
            err_q            <= ERR_NONE;
            cmd_q            <= '0;
            sum_q            <= '0;
            rem_q            <= '0;
            pkt_start_o      <= 1'b0;
            pkt_cmd_o        <= '0;
            pkt_len_o        <= '0;
            pkt_data_valid_o <= 1'b0;
            pkt_data_o       <= '0;
            pkt_done_o       <= 1'b0;
            pkt_err_o        <= 1'b0;
            busy_o           <= 1'b0;
        end else begin
            state            <= state_n;
            err_q            <= err_n;
            cmd_q            <= cmd_n;
            sum_q            <= sum_n;
            rem_q            <= rem_n;
            pkt_start_o      <= start_n;
            pkt_cmd_o        <= pkt_cmd_n;
            pkt_len_o        <= pkt_len_n;
            pkt_data_valid_o <= dv_n;
            pkt_data_o       <= pkt_data_n;
            pkt_done_o       <= done_n;
            pkt_err_o        <= perr_n;
            busy_o           <= (state_n != ST_IDLE);
        end
    end

    assign err_code_o = err_q;

endmodule

// File: tb/tb_uart_pkt_ctrl.sv
// Directed bench for uart_pkt_ctrl with a short gap timeout and MAX_LEN of 16.
module tb_uart_pkt_ctrl;

    localparam int unsigned T = 20;   // TIMEOUT_CNT for 1 MHz, 20 us

    logic       sys_clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       rx_valid_i = 1'b0;
    logic [7:0] rx_data_i = '0;
    logic       pkt_start_o, pkt_data_valid_o, pkt_done_o, pkt_err_o, busy_o;
    logic [7:0] pkt_cmd_o, pkt_len_o, pkt_data_o;
    logic [1:0] err_code_o;

    int checks = 0;
    int errors = 0;

    uart_pkt_ctrl #(
        .CLK_FREQ   (1_000_000),
        .TIMEOUT_US (20),
        .MAX_LEN    (16)
    ) dut (
        .sys_clk          (sys_clk),
        .sys_rst_n        (sys_rst_n),
        .rx_valid_i       (rx_valid_i),
        .rx_data_i        (rx_data_i),
        .pkt_start_o      (pkt_start_o),
        .pkt_cmd_o        (pkt_cmd_o),
        .pkt_len_o        (pkt_len_o),
        .pkt_data_valid_o (pkt_data_valid_o),
        .pkt_data_o       (pkt_data_o),
        .pkt_done_o       (pkt_done_o),
        .pkt_err_o        (pkt_err_o),
        .err_code_o       (err_code_o),
        .busy_o           (busy_o)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Strobe one byte; returns just after the edge that registered the response
    task automatic send(input logic [7:0] b);
        @(negedge sys_clk);
        rx_valid_i = 1'b1;
        rx_data_i  = b;
        @(posedge sys_clk);
        #1;
        rx_valid_i = 1'b0;
    endtask

    // {start, dv, done, err}
    function automatic logic [3:0] pulses();
        return {pkt_start_o, pkt_data_valid_o, pkt_done_o, pkt_err_o};
    endfunction

    function automatic logic [43:0] all_out();
        return {pkt_start_o, pkt_cmd_o, pkt_len_o, pkt_data_valid_o, pkt_data_o,
                pkt_done_o, pkt_err_o, err_code_o, busy_o, 8'h00};
    endfunction

    task automatic good_frame(input string tag);
        send(8'hA5); send(8'h5A); send(8'h10);
        send(8'h03);
        check({tag, "_start"}, {pulses(), pkt_cmd_o, pkt_len_o, 2'b00, err_code_o}, {4'b1000, 8'h10, 8'h03, 4'h0});
        send(8'h11); check({tag, "_d0"}, {pulses(), pkt_data_o}, {4'b0100, 8'h11});
        send(8'h22); check({tag, "_d1"}, {pulses(), pkt_data_o}, {4'b0100, 8'h22});
        send(8'h33); check({tag, "_d2"}, {pulses(), pkt_data_o}, {4'b0100, 8'h33});
        send(8'h79);
        check({tag, "_done"}, {pulses(), 2'b00, err_code_o, 3'b000, busy_o}, {4'b0010, 4'h0, 4'h0});
    endtask

    initial begin
        logic       seen;
        logic [7:0] dvs;

        // Reset state
        #2;
        check("reset_outputs", 32'(all_out() >> 8), 32'h0);
        check("reset_outputs_hi", 32'(all_out() >> 40), 32'h0);
        repeat (3) @(posedge sys_clk);
        #1 sys_rst_n = 1'b1;

        // 1: nominal frame
        good_frame("t1");
        @(posedge sys_clk); #1;
        check("t1_pulses_clear", {28'h0, pulses()}, 32'h0);

        // 2: bad checksum, then a good frame recovers
        send(8'hA5); send(8'h5A); send(8'h10); send(8'h03);
        send(8'h11); send(8'h22);
        send(8'h33); check("t2_d2", {pulses(), pkt_data_o}, {4'b0100, 8'h33});
        send(8'h78);
        check("t2_chkerr", {pulses(), 2'b00, err_code_o, 3'b000, busy_o}, {4'b0001, 4'h1, 4'h0});
        good_frame("t2_recover");

        // 3a: stall after first payload byte -> timeout exactly T+1 cycles later
        send(8'hA5); send(8'h5A); send(8'h20); send(8'h02);
        send(8'h44);
        seen = 1'b0;
        for (int k = 1; k < T + 1; k++) begin
            @(posedge sys_clk); #1;
            if (pkt_err_o || !busy_o) seen = 1'b1;
        end
        check("t3_no_early_timeout", {31'h0, seen}, 32'h0);
        @(posedge sys_clk); #1;
        check("t3_timeout", {pulses(), 2'b00, err_code_o, 3'b000, busy_o}, {4'b0001, 4'h2, 4'h0});

        // 3b: byte strobed on the expiry cycle wins
        send(8'hA5); send(8'h5A); send(8'h20);
        send(8'h02);
        check("t3_restart_code", {30'h0, err_code_o}, 32'h0);
        send(8'h44);
        repeat (T) @(posedge sys_clk);
        send(8'h55);
        check("t3_expiry_byte", {pulses(), pkt_data_o, 3'b000, busy_o}, {4'b0100, 8'h55, 4'h1});
        send(8'hBB);
        check("t3_expiry_done", {pulses(), 2'b00, err_code_o}, {4'b0010, 4'h0});

        // 4: resync through noise and repeated A5, zero-length frame
        send(8'h00); check("t4_noise_idle", {pulses(), 3'b000, busy_o}, {4'b0000, 4'h0});
        send(8'hA5); send(8'hA5);
        check("t4_head_hold", {pulses(), 3'b000, busy_o}, {4'b0000, 4'h1});
        send(8'h5A); send(8'h01);
        send(8'h00);
        check("t4_start", {pulses(), pkt_cmd_o, pkt_len_o}, {4'b1000, 8'h01, 8'h00});
        send(8'h01);
        check("t4_done", {pulses(), 2'b00, err_code_o, 3'b000, busy_o}, {4'b0010, 4'h0, 4'h0});

        // 5: LEN 17 rejected with MAX_LEN 16; LEN 16 accepted
        send(8'hA5); send(8'h5A); send(8'h01);
        send(8'h11);
        check("t5_lenerr", {pulses(), pkt_cmd_o, pkt_len_o, 2'b00, err_code_o, 3'b000, busy_o},
              {4'b0001, 8'h01, 8'h00, 4'h3, 4'h0});
        send(8'hA5); send(8'h5A); send(8'h03);
        send(8'h10);
        check("t5_len16_start", {pulses(), pkt_cmd_o, pkt_len_o, 2'b00, err_code_o}, {4'b1000, 8'h03, 8'h10, 4'h0});
        dvs = '0;
        for (int i = 0; i < 16; i++) begin
            send(8'(i));
            if (pkt_data_valid_o && (pkt_data_o == 8'(i))) dvs++;
        end
        check("t5_len16_payload", {24'h0, dvs}, 32'd16);
        send(8'h8B);
        check("t5_len16_done", {28'h0, pulses()}, {28'h0, 4'b0010});

        // 6: asynchronous reset mid-payload, then a clean frame
        send(8'hA5); send(8'h5A); send(8'h10); send(8'h03); send(8'h11);
        @(negedge sys_clk);
        sys_rst_n = 1'b0;
        #1;
        check("t6_reset_lo", 32'(all_out() >> 8), 32'h0);
        check("t6_reset_hi", 32'(all_out() >> 40), 32'h0);
        repeat (2) @(posedge sys_clk);
        #1 sys_rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < T + 5; k++) begin
            @(posedge sys_clk); #1;
            if (pkt_err_o || busy_o) seen = 1'b1;
        end
        check("t6_silent_after_reset", {31'h0, seen}, 32'h0);
        good_frame("t6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
